alu_unit: RTL and testbench
===========================

ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, operand/result width (>=4).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request; sampled only when busy=0.
REQ-005 SHALL have port op  input  3  operation: 0 ADD, 1 SUB, 2 ADC, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 MUL.
REQ-006 SHALL have port a  input  DATA_BITS  operand A.
REQ-007 SHALL have port b  input  DATA_BITS  operand B.
REQ-008 SHALL have port cin  input  1  carry-in for ADC/SBC.
REQ-009 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result/flags updated.
REQ-011 SHALL have port result  output  DATA_BITS  registered result.
REQ-012 SHALL have port flags  output  4  registered {N, V, C, Z} (bit3..bit0).

Function
REQ-013 SHALL capture a, b, cin, op on the rising edge where start=1 and busy=0.
REQ-014 SHALL ignore start while busy=1; no operand capture, no state change.
REQ-015 Ops 0-6 SHALL update result/flags and pulse done on the same edge that captures start (1-cycle latency).
REQ-016 ADD: {C,result} = a+b; ADC: a+b+cin.
REQ-017 SUB: {C,result} = a+~b+1; SBC: a+~b+cin; C=1 means no borrow.
REQ-018 AND/OR/XOR: bitwise; C=0, V=0.
REQ-019 V SHALL be two's-complement signed overflow for ops 0-3 (operand B taken as ~b for SUB/SBC).
REQ-020 Z SHALL be (result==0); N SHALL be result[DATA_BITS-1]; for all ops.
REQ-021 FSM states IDLE, MUL; IDLE->MUL on accepted start with op=7; MUL->IDLE after DATA_BITS iterations.
REQ-022 MUL SHALL be shift-add, one bit of b per cycle, LSB first, 2*DATA_BITS-bit internal accumulator.
REQ-023 busy SHALL be 1 exactly while in MUL; done SHALL pulse on the MUL->IDLE edge, DATA_BITS cycles after the capture edge.
REQ-024 MUL result SHALL be low DATA_BITS of the product; C = OR of high DATA_BITS; V=0.
REQ-025 result and flags SHALL hold their last value until the next done pulse.
REQ-026 done SHALL be 0 in every cycle without a completion; never asserted two consecutive cycles for one request.
REQ-027 A new start SHALL be accepted on the edge after done (busy already 0), enabling back-to-back ops.

Reset
REQ-028 reset_n=0 SHALL immediately force state IDLE, busy=0, done=0, result=0, flags=0, accumulator=0.
REQ-029 Reset during MUL SHALL abort the multiply with no done pulse, after or during reset.
REQ-030 First start SHALL be accepted on the first rising edge with reset_n=1.

Configuration
REQ-031 Macro ALU_MUL_EN SHALL compile in the MUL state, accumulator and op 7 multiply.
REQ-032 Without ALU_MUL_EN, op 7 SHALL complete in 1 cycle with result=0, flags={0,0,0,1}; busy SHALL be constant 0; no MUL state present.

Verification (DATA_BITS=8)
REQ-033 ADD a=0x7F b=0x01 -> next edge done=1, result=0x80, N=1 V=1 C=0 Z=0.
REQ-034 SUB a=0x05 b=0x05 -> result=0x00, Z=1 C=1; SUB a=0x03 b=0x05 -> result=0xFE, N=1 C=0.
REQ-035 ADC a=0xFF b=0x00 cin=1 -> result=0x00, C=1 Z=1; XOR a=0xAA b=0xFF -> 0x55, flags=0.
REQ-036 MUL (ALU_MUL_EN) a=0x10 b=0x10 -> busy=1 for 8 cycles, done on 8th edge, result=0x00, C=1 Z=1; a=0x0F b=0x11 -> 0xFF, C=0 N=1; start pulses while busy ignored.
REQ-037 MUL started, reset_n=0 at cycle 4 -> busy=0, result=0, flags=0 immediately; no done; ADD issued after release completes normally.
REQ-038 Without ALU_MUL_EN, op 7 a=0x10 b=0x10 -> 1 cycle, busy never 1, result=0x00, flags=0b0001.

Source files
------------

// File: rtl/alu_unit.sv
// Registered ALU with add/sub/carry ops, bitwise ops and an optional shift-add multiplier.
// Define ALU_MUL_EN to build the multi-cycle multiply for op 7; otherwise op 7 returns zero.
module alu_unit #(
   parameter int unsigned DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [2:0]           op,
   input  logic [DATA_BITS-1:0] a,
   input  logic [DATA_BITS-1:0] b,
   input  logic                 cin,
   output logic                 busy,
   output logic                 done,
   output logic [DATA_BITS-1:0] result,
   output logic [3:0]           flags
);

   localparam int unsigned W  = DATA_BITS;
   localparam int unsigned W1 = DATA_BITS + 1;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_ADC = 3'd2;
   localparam logic [2:0] OP_SBC = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_OR  = 3'd5;
   localparam logic [2:0] OP_XOR = 3'd6;

   logic [W-1:0] b_eff;
   logic         cin_eff;
   logic [W:0]   sum;
   logic [W-1:0] alu_res;
   logic         alu_c;
   logic         alu_v;
   logic [3:0]   alu_flags;

   logic [W-1:0] result_q, result_d;
   logic [3:0]   flags_q, flags_d;
   logic         done_q, done_d;

   // Single-cycle datapath; subtraction is a + ~b + carry so C=1 means no borrow
   always_comb begin
      b_eff   = ((op == OP_SUB) || (op == OP_SBC)) ? ~b : b;
      cin_eff = 1'b0;
      case (op)
         OP_SUB:         cin_eff = 1'b1;
         OP_ADC, OP_SBC: cin_eff = cin;
         default:        cin_eff = 1'b0;
      endcase
      sum     = {1'b0, a} + {1'b0, b_eff} + W1'(cin_eff);
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op)
         OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
            alu_res = sum[W-1:0];
            alu_c   = sum[W];
            alu_v   = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         default: alu_res = '0;
      endcase
      alu_flags = {alu_res[W-1], alu_v, alu_c, (alu_res == '0)};
   end

`ifdef ALU_MUL_EN
   localparam int unsigned CNT_W = $clog2(DATA_BITS);
   localparam int unsigned PW    = 2 * DATA_BITS;
   localparam logic [2:0]  OP_MUL = 3'd7;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [PW-1:0]    mcand_q, mcand_d;
   logic [W-1:0]     mplier_q, mplier_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [PW-1:0]    prod;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         done_q   <= done_d;
      end
   end

   // Next state: one multiplier bit per cycle, LSB first, into a double-width accumulator
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      flags_d  = flags_q;
      done_d   = 1'b0;
      prod     = acc_q + (mplier_q[0] ? mcand_q : '0);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (op == OP_MUL) begin
                  state_d  = S_MUL;
                  acc_d    = '0;
                  mcand_d  = {{W{1'b0}}, a};
                  mplier_d = b;
                  cnt_d    = '0;
               end else begin
                  result_d = alu_res;
                  flags_d  = alu_flags;
                  done_d   = 1'b1;
               end
            end
         end
         S_MUL: begin
            acc_d    = prod;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(W - 1)) begin
               state_d  = S_IDLE;
               result_d = prod[W-1:0];
               flags_d  = {prod[W-1], 1'b0, |prod[PW-1:W], (prod[W-1:0] == '0)};
               done_d   = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_MUL);
   end

   assign busy = busy_q;
`else
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         result_q <= '0;
         flags_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         result_q <= result_d;
         flags_q  <= flags_d;
         done_q   <= done_d;
      end
   end

   // Every request completes in one cycle; op 7 falls through to a zero result
   always_comb begin
      result_d = result_q;
      flags_d  = flags_q;
      done_d   = 1'b0;
      if (start) begin
         result_d = alu_res;
         flags_d  = alu_flags;
         done_d   = 1'b1;
      end
   end

   assign busy = 1'b0;
`endif

   assign done   = done_q;
   assign result = result_q;
   assign flags  = flags_q;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vectors, reset behaviour and random ops
// against an arithmetic reference model.
module tb_alu_unit;

   localparam int unsigned DW = 8;
`ifdef ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [2:0]    op;
   logic [DW-1:0] a;
   logic [DW-1:0] b;
   logic          cin;
   logic          busy;
   logic          done;
   logic [DW-1:0] result;
   logic [3:0]    flags;

   int unsigned   checks = 0;
   int unsigned   errors = 0;
   logic [DW-1:0] last_res;
   logic [3:0]    last_flags;

   always #5 clk = ~clk;

   alu_unit #(.DATA_BITS(DW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .result(result), .flags(flags)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference: signed/unsigned integer arithmetic, returns {N,V,C,Z,result}
   function automatic logic [11:0] model(input logic [2:0] o, input logic [7:0] x,
                                         input logic [7:0] y, input logic c);
      int ua = int'(x);
      int ub = int'(y);
      int sa = int'($signed(x));
      int sb = int'($signed(y));
      int r  = 0;
      int s  = 0;
      logic [7:0] res;
      logic cf = 1'b0;
      logic vf = 1'b0;
      case (o)
         3'd0: begin r = ua + ub;               s = sa + sb;               end
         3'd1: begin r = ua + (255 - ub) + 1;   s = sa + (-sb - 1) + 1;    end
         3'd2: begin r = ua + ub + int'(c);     s = sa + sb + int'(c);     end
         3'd3: begin r = ua + (255 - ub) + int'(c); s = sa + (-sb - 1) + int'(c); end
         3'd4: r = int'(x & y);
         3'd5: r = int'(x | y);
         3'd6: r = int'(x ^ y);
         default: r = MUL_EN ? ua * ub : 0;
      endcase
      res = 8'(r % 256);
      if (o <= 3'd3) begin
         cf = (r > 255);
         vf = (s > 127) || (s < -128);
      end else if (o == 3'd7) begin
         cf = (r / 256) != 0;
      end
      return {res[7], vf, cf, (res == 8'h00), res};
   endfunction

   // Issue one request and check timing plus final result; gap adds an idle cycle afterwards
   task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] x,
                         input logic [7:0] y, input logic c, input logic [7:0] er,
                         input logic [3:0] ef, input bit gap);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y; cin = c;
      @(posedge clk); #1;
      start = 1'b0;
      if (MUL_EN && o == 3'd7) begin
         chk({tag, "_busy_cap"}, 32'(busy), 32'd1);
         chk({tag, "_done_cap"}, 32'(done), 32'd0);
         for (int k = 1; k <= int'(DW); k++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            op = 3'($urandom); a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            @(posedge clk); #1;
            start = 1'b0;
            if (k < int'(DW)) begin
               chk({tag, "_busy"}, 32'(busy), 32'd1);
               chk({tag, "_done_early"}, 32'(done), 32'd0);
               chk({tag, "_hold"}, 32'(result), 32'(last_res));
            end
         end
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
      chk({tag, "_res"}, 32'(result), 32'(er));
      chk({tag, "_flags"}, 32'(flags), 32'(ef));
      last_res = er;
      last_flags = ef;
      if (gap) begin
         @(posedge clk); #1;
         chk({tag, "_done_once"}, 32'(done), 32'd0);
         chk({tag, "_res_hold"}, 32'(result), 32'(last_res));
         chk({tag, "_flags_hold"}, 32'(flags), 32'(last_flags));
      end
   endtask

   task automatic run_model(input string tag, input logic [2:0] o, input logic [7:0] x,
                            input logic [7:0] y, input logic c, input bit gap);
      logic [11:0] e;
      e = model(o, x, y, c);
      run_op(tag, o, x, y, c, e[7:0], e[11:8], gap);
   endtask

   initial begin
      logic [2:0] ro;
      reset_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
      last_res = '0; last_flags = '0;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_res", 32'(result), 32'd0);
      chk("rst_flags", 32'(flags), 32'd0);

      // First start accepted on the first edge after release
      @(negedge clk);
      reset_n = 1'b1; start = 1'b1; op = 3'd0; a = 8'd1; b = 8'd2;
      @(posedge clk); #1;
      start = 1'b0;
      chk("first_done", 32'(done), 32'd1);
      chk("first_res", 32'(result), 32'd3);
      last_res = 8'd3; last_flags = 4'b0000;

      run_op("add_ovf", 3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b1100, 1'b1);
      run_op("sub_eq",  3'd1, 8'h05, 8'h05, 1'b0, 8'h00, 4'b0011, 1'b0);
      run_op("sub_brw", 3'd1, 8'h03, 8'h05, 1'b0, 8'hFE, 4'b1000, 1'b1);
      run_op("adc_wrap",3'd2, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b0011, 1'b0);
      run_op("xor",     3'd6, 8'hAA, 8'hFF, 1'b0, 8'h55, 4'b0000, 1'b1);
      if (MUL_EN) begin
         run_op("mul_hi", 3'd7, 8'h10, 8'h10, 1'b0, 8'h00, 4'b0011, 1'b0);
         run_op("mul_lo", 3'd7, 8'h0F, 8'h11, 1'b0, 8'hFF, 4'b1000, 1'b0);
         run_op("b2b_add",3'd0, 8'h01, 8'h01, 1'b0, 8'h02, 4'b0000, 1'b1);
      end else begin
         run_op("op7_nomul", 3'd7, 8'h10, 8'h10, 1'b0, 8'h00, 4'b0001, 1'b1);
      end

      // Reset in the middle of a request (a multiply when present)
      @(negedge clk);
      start = 1'b1; op = 3'd7; a = 8'h33; b = 8'h55;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_res", 32'(result), 32'd0);
      chk("mrst_flags", 32'(flags), 32'd0);
      last_res = '0; last_flags = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < int'(DW) + 2; k++) begin
         @(posedge clk); #1;
         chk("mrst_nodone", 32'(done), 32'd0);
      end
      run_op("post_rst_add", 3'd0, 8'h20, 8'h22, 1'b0, 8'h42, 4'b0000, 1'b1);

      // Random ops against the reference model
      for (int i = 0; i < 80; i++) begin
         ro = 3'($urandom);
         run_model($sformatf("rnd%0d_op%0d", i, ro), ro, 8'($urandom), 8'($urandom),
                   1'($urandom), bit'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
